// File: rtl/blink_pkg.sv
// Shared mode encoding and elaboration helpers for the multi-channel blink generator.
package blink_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  function automatic int calcPresc(input int clkHz, input int tickHz);
    return clkHz / tickHz;
  endfunction

  function automatic int prescWidth(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink channel: tick-driven period counter, registered mode copy and out/busy logic
// for TOGGLE, PULSE and ONESHOT behaviour.
module blink_channel
  import blink_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_start,
  output logic             o_out,
  output logic             o_busy
);

  mode_e            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_busy;

  mode_e            w_mode_in;
  logic             w_mode_chg;
  logic             w_period_zero;
  logic             w_at_end;
  logic             w_run;
  logic             w_event;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_busy_nxt;

  assign w_mode_in = mode_e'(i_mode);

  // A ONESHOT channel only counts while busy, so an idle channel sits quietly at zero.
  always_comb begin
    w_mode_chg    = (w_mode_in != r_mode);
    w_period_zero = (i_period == '0);
    w_at_end      = (r_cnt >= (i_period - CNT_W'(1)));
    w_run         = 1'b0;
    unique case (r_mode)
      MODE_TOGGLE,
      MODE_PULSE:   w_run = i_tick && !w_period_zero;
      MODE_ONESHOT: w_run = i_tick && !w_period_zero && r_busy;
      default:      w_run = 1'b0;
    endcase
    w_event = w_run && w_at_end;
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_out_nxt  = r_out;
    w_busy_nxt = r_busy;

    if (w_run) begin
      w_cnt_nxt = w_at_end ? '0 : r_cnt + CNT_W'(1);
    end

    unique case (r_mode)
      MODE_OFF: begin
        w_cnt_nxt  = '0;
        w_out_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
      end
      MODE_TOGGLE: begin
        w_busy_nxt = 1'b0;
        if (w_event) begin
          w_out_nxt = ~r_out;
        end
      end
      MODE_PULSE: begin
        w_busy_nxt = 1'b0;
        w_out_nxt  = w_event;
      end
      MODE_ONESHOT: begin
        if (r_busy) begin
          if (w_event) begin
            w_out_nxt  = 1'b0;
            w_busy_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = '0;
          w_out_nxt = 1'b0;
          if (i_start) begin
            w_busy_nxt = 1'b1;
            w_out_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_cnt_nxt  = '0;
        w_out_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase

    // Clearing conditions override everything, including a start in the same cycle.
    if (w_period_zero || w_mode_chg || i_clear) begin
      w_cnt_nxt  = '0;
      w_out_nxt  = 1'b0;
      w_busy_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= MODE_OFF;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_mode <= w_mode_in;
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_out_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;

endmodule

// File: rtl/multi_blink_gen.sv
// Multi-channel blink/tick generator: shared prescaler producing a base tick plus N_CH channels.
// Define BLINK_SYNC_EN to add the 'sync' input that phase-aligns prescaler and all channels.
module multi_blink_gen
  import blink_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
`ifdef BLINK_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [MODE_W*N_CH-1:0]  ch_mode,
  input  logic [CNT_W*N_CH-1:0]   ch_period,
  input  logic [N_CH-1:0]         ch_start,
  output logic                    tick,
  output logic [N_CH-1:0]         out,
  output logic [N_CH-1:0]         busy
);

  localparam int PRESC   = calcPresc(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = prescWidth(PRESC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

  if (PRESC < 2) begin : g_bad_presc
    $error("multi_blink_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("multi_blink_gen: N_CH must be in 1..16");
  end

  logic               w_sync;
  logic [PRESC_W-1:0] r_presc;

`ifdef BLINK_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_sync) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
    end
  end

  assign tick = en && !w_sync && (r_presc == PRESC_LAST);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    blink_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (tick),
      .i_clear  (w_sync),
      .i_mode   (ch_mode[MODE_W*gi +: MODE_W]),
      .i_period (ch_period[CNT_W*gi +: CNT_W]),
      .i_start  (ch_start[gi]),
      .o_out    (out[gi]),
      .o_busy   (busy[gi])
    );
  end

endmodule

// File: tb/tb_multi_blink_gen.sv
// Directed bench for multi_blink_gen: PRESC=10, N_CH=4, CNT_W=8, expected edges computed by hand.
module tb_multi_blink_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst;
  logic                  en;
`ifdef BLINK_SYNC_EN
  logic                  sync;
`endif
  logic [2*N_CH-1:0]     ch_mode;
  logic [CNT_W*N_CH-1:0] ch_period;
  logic [N_CH-1:0]       ch_start;
  logic                  tick;
  logic [N_CH-1:0]       out;
  logic [N_CH-1:0]       busy;

  int checks = 0;
  int errors = 0;
  int edgeNo = 0;

  multi_blink_gen #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .N_CH    (N_CH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef BLINK_SYNC_EN
    .sync      (sync),
`endif
    .ch_mode   (ch_mode),
    .ch_period (ch_period),
    .ch_start  (ch_start),
    .tick      (tick),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic [N_CH-1:0] startV);
    en       = enV;
    ch_start = startV;
  endtask

  // Advance to just after rising edge n (counted from the last reset release).
  task automatic waitTo(input int n);
    while (edgeNo < n) begin
      @(posedge clk);
      edgeNo++;
    end
    #1;
  endtask

  logic sawHigh;

  initial begin
    rst       = 1'b0;
`ifdef BLINK_SYNC_EN
    sync      = 1'b0;
`endif
    applyStimulus(1'b1, 4'b0000);
    ch_mode   = {2'b00, 2'b11, 2'b10, 2'b01};
    ch_period = {8'd0, 8'd4, 8'd3, 8'd5};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tick", tick, 1'b0);
    checkOutput("reset_out",  out,  4'b0000);
    checkOutput("reset_busy", busy, 4'b0000);
    @(negedge clk);
    rst    = 1'b1;
    edgeNo = 0;

    // Prescaler and TOGGLE/PULSE start-up timing.
    waitTo(8);   checkOutput("tick@8",  tick, 1'b0);
    waitTo(9);   checkOutput("tick@9",  tick, 1'b1);
    waitTo(10);  checkOutput("tick@10", tick, 1'b0);
                 checkOutput("pulse@10", out[1], 1'b0);
    waitTo(29);  checkOutput("pulse@29", out[1], 1'b0);
    waitTo(30);  checkOutput("pulse@30", out[1], 1'b1);
    waitTo(31);  checkOutput("pulse@31", out[1], 1'b0);
    waitTo(49);  checkOutput("tog@49",  out[0], 1'b0);
    waitTo(50);  checkOutput("tog@50",  out[0], 1'b1);
                 checkOutput("os_idle", busy[2], 1'b0);
                 checkOutput("off_ch3", out[3], 1'b0);
    waitTo(60);  checkOutput("pulse@60", out[1], 1'b1);
    waitTo(61);  checkOutput("pulse@61", out[1], 1'b0);
    waitTo(99);  checkOutput("tog@99",  out[0], 1'b1);
    waitTo(100); checkOutput("tog@100", out[0], 1'b0);

    // ONESHOT with an ignored retrigger.
    applyStimulus(1'b1, 4'b0100);
    waitTo(101); checkOutput("os_busy@101", busy[2], 1'b1);
                 checkOutput("os_out@101",  out[2],  1'b1);
    applyStimulus(1'b1, 4'b0000);
    waitTo(114); applyStimulus(1'b1, 4'b0100);
    waitTo(115); applyStimulus(1'b1, 4'b0000);
    waitTo(139); checkOutput("os_busy@139", busy[2], 1'b1);
    waitTo(140); checkOutput("os_busy@140", busy[2], 1'b0);
                 checkOutput("os_out@140",  out[2],  1'b0);
    waitTo(150); checkOutput("tog@150", out[0], 1'b1);

    // Enable low for 25 clocks shifts the next toggle from 200 to 225.
    waitTo(160); applyStimulus(1'b0, 4'b0000);
    waitTo(169); checkOutput("tick_en0", tick, 1'b0);
    waitTo(185); applyStimulus(1'b1, 4'b0000);
    waitTo(194); checkOutput("tick@194", tick, 1'b1);
    waitTo(200); checkOutput("tog_hold@200", out[0], 1'b1);
    waitTo(224); checkOutput("tog@224", out[0], 1'b1);
    waitTo(225); checkOutput("tog@225", out[0], 1'b0);

    // Period shrink from 5 to 2 with cnt=3, then period 0.
    waitTo(255); ch_period[7:0] = 8'd2;
    waitTo(264); checkOutput("shrink@264", out[0], 1'b0);
    waitTo(265); checkOutput("shrink@265", out[0], 1'b1);
    waitTo(285); checkOutput("p2@285", out[0], 1'b0);
    waitTo(305); checkOutput("p2@305", out[0], 1'b1);
    ch_period[7:0] = 8'd0;
    waitTo(306); checkOutput("p0@306", out[0], 1'b0);
    sawHigh = 1'b0;
    for (int i = 307; i <= 506; i++) begin
      waitTo(i);
      sawHigh = sawHigh | out[0];
    end
    checkOutput("p0_quiet", sawHigh, 1'b0);

    // Asynchronous reset mid-TOGGLE and mid-ONESHOT, during a tick cycle.
    ch_period[7:0] = 8'd5;
    waitTo(539); applyStimulus(1'b1, 4'b0100);
    waitTo(540); applyStimulus(1'b1, 4'b0000);
    waitTo(555); checkOutput("pre_rst_tog", out[0], 1'b1);
    waitTo(564); checkOutput("pre_rst_tick", tick, 1'b1);
                 checkOutput("pre_rst_busy", busy[2], 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_tick", tick, 1'b0);
    checkOutput("rst_out",  out,  4'b0000);
    checkOutput("rst_busy", busy, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    edgeNo = 0;
    waitTo(9);  checkOutput("rel_tick@9", tick, 1'b1);
    waitTo(49); checkOutput("rel_tog@49", out[0], 1'b0);
                checkOutput("rel_busy",   busy[2], 1'b0);
    waitTo(50); checkOutput("rel_tog@50", out[0], 1'b1);

`ifdef BLINK_SYNC_EN
    // Sync realigns ch0 and a freshly reprogrammed ch1 so both toggle together.
    ch_mode[3:2]    = 2'b01;
    ch_period[15:8] = 8'd5;
    waitTo(52); sync = 1'b1;
    waitTo(53); sync = 1'b0;
                checkOutput("sync_out", out[1:0], 2'b00);
    waitTo(62); checkOutput("sync_tick", tick, 1'b1);
    waitTo(102); checkOutput("sync@102", out[1:0], 2'b00);
    waitTo(103); checkOutput("sync@103", out[1:0], 2'b11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
